// File: rtl/pwm_multichannel_peripheral_if.sv
// rtl/pwm_multichannel_peripheral_if.sv - configuration, duty write port and pin outputs of the PWM peripheral
interface pwm_multichannel_peripheral_if #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]  en_out;
    logic [NUM_CH-1:0]  en_pwm;
    logic               duty_we;
    logic [SEL_W-1:0]   duty_wsel;
    logic [CNT_W-1:0]   duty_wdata;
    logic [CNT_W-1:0]   period_top;
    logic [PRESC_W-1:0] prescale;
    logic               center_mode;
    logic [NUM_CH-1:0]  pwm_out;
    logic               period_tick;

    modport master (
        output en_out, en_pwm, duty_we, duty_wsel, duty_wdata,
               period_top, prescale, center_mode,
        input  pwm_out, period_tick
    );

    modport slave (
        input  en_out, en_pwm, duty_we, duty_wsel, duty_wdata,
               period_top, prescale, center_mode,
        output pwm_out, period_tick
    );
endinterface

// File: rtl/pwm_multichannel_peripheral.sv
// rtl/pwm_multichannel_peripheral.sv - multi-channel PWM with shadowed duty/period/prescale and edge/centre modes
module pwm_multichannel_peripheral #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    pwm_multichannel_peripheral_if.slave  bus
);
    logic [CNT_W-1:0]   sh_duty  [NUM_CH];
    logic [CNT_W-1:0]   act_duty [NUM_CH];
    logic [CNT_W-1:0]   sh_top, act_top;
    logic [PRESC_W-1:0] sh_presc, act_presc;
    logic               sh_mode, act_mode;
    logic [PRESC_W-1:0] psc;
    logic [CNT_W-1:0]   cnt;
    logic               dir_down;

    logic               cnt_en;
    logic               boundary;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               dir_down_nxt;
    logic [NUM_CH-1:0]  raw;

    always_comb begin
        cnt_en       = (psc == act_presc);
        cnt_nxt      = cnt;
        dir_down_nxt = dir_down;
        if (!act_mode) begin
            cnt_nxt = (cnt >= act_top) ? '0 : cnt + CNT_W'(1);
        end else if (dir_down) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else if (cnt >= act_top) begin
            // Peak reached: turn around without repeating the top value.
            cnt_nxt      = (act_top == '0) ? '0 : act_top - CNT_W'(1);
            dir_down_nxt = 1'b1;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        // Arriving at zero is the period boundary and always restarts counting upward.
        if (cnt_nxt == '0) begin
            dir_down_nxt = 1'b0;
        end
        boundary = cnt_en && ((cnt_nxt == '0) || (act_top == '0));
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (cnt < act_duty[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_duty[i]  <= '0;
                act_duty[i] <= '0;
            end
            sh_top          <= '0;
            act_top         <= '0;
            sh_presc        <= '0;
            act_presc       <= '0;
            sh_mode         <= 1'b0;
            act_mode        <= 1'b0;
            psc             <= '0;
            cnt             <= '0;
            dir_down        <= 1'b0;
            bus.pwm_out     <= '0;
            bus.period_tick <= 1'b0;
        end else begin
            sh_top   <= bus.period_top;
            sh_presc <= bus.prescale;
            sh_mode  <= bus.center_mode;
            if (bus.duty_we && (int'(bus.duty_wsel) < NUM_CH)) begin
                sh_duty[bus.duty_wsel] <= bus.duty_wdata;
            end

            if (cnt_en) begin
                psc      <= '0;
                cnt      <= cnt_nxt;
                dir_down <= dir_down_nxt;
            end else begin
                psc <= psc + PRESC_W'(1);
            end

            // Active copies take the pre-write shadow values, so a same-cycle write waits a period.
            if (boundary) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    act_duty[i] <= sh_duty[i];
                end
                act_top   <= sh_top;
                act_presc <= sh_presc;
                act_mode  <= sh_mode;
            end

            bus.period_tick <= boundary;
            bus.pwm_out     <= bus.en_out & (~bus.en_pwm | raw);
        end
    end
endmodule
